// File: rtl/serializing_pe.sv
// Replays one captured ImageSize-element vector as a serial stream, highest index first, after Delay idle cycles.
// First element valid Delay+1 cycles after capture; out_ready=0 holds element and index; in_ready only while idle.
module serializing_pe #(
    parameter int BitSize   = 2,
    parameter int ImageSize = 9,
    parameter int Delay     = 0
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ImageSize-1:0][BitSize-1:0]   in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BitSize-1:0]                  out_data,
    output logic                                out_done
);

    localparam int IW = $clog2(ImageSize + Delay + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(ImageSize - 1);
    localparam logic [IW-1:0] WAIT_END = IW'((Delay > 0) ? Delay - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t                           state, state_nxt;
    logic [IW-1:0]                    idx_r, idx_nxt;
    logic [ImageSize-1:0][BitSize-1:0] vec_r;
    logic                             load;
    logic [IW-1:0]                    sel;

    assign sel = LAST_IDX - idx_r;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_r;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_done  = 1'b0;
        out_data  = '0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                // Held low during reset so nothing is captured until release.
                in_ready = ~res_n;
                if (in_valid && !res_n) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = (Delay > 0) ? WAIT : SEND;
                end
            end
            WAIT: begin
                if (idx_r == WAIT_END) begin
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end else begin
                    idx_nxt = idx_r + 1'b1;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = vec_r[sel];
                if (out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        out_done  = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx_r + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            state <= IDLE;
            idx_r <= '0;
            vec_r <= '0;
        end else begin
            state <= state_nxt;
            idx_r <= idx_nxt;
            if (load) begin
                vec_r <= in_data;
            end
        end
    end

endmodule

// File: doc/serializing_pe.md
Name: serializing_pe

Overview:
- Converse of the flattening PE: accepts one full flattened vector of ImageSize elements in a single handshake and replays it as a serial stream, one BitSize element per accepted beat.
- Element order matches the flattening PE: index ImageSize-1 is emitted first and index 0 last, so a flattening PE fed by this block reconstructs the original vector.
- An optional Delay of idle cycles runs before the first element.
- Sits between a dense/fully-connected stage and a downstream stream-consuming PE.

Parameters:
- BitSize, 2, width of one element.
- ImageSize, 9, number of elements per vector (>=1).
- Delay, 0, idle cycles between vector capture and the first out_valid (>=0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- res_n  input  1  reset; asynchronous and active-high.
- in_valid  input  1  upstream presents a vector on in_data.
- in_ready  output  1  block can capture a vector this cycle.
- in_data  input  [ImageSize-1:0][BitSize-1:0]  vector to serialize.
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  BitSize  current element.
- out_done  output  1  single-cycle pulse on the beat the last element (index 0) is accepted.

Behaviour:
- Reset (res_n=1, async): state IDLE, vector register 0, counter 0, out_valid=0, out_data=0, out_done=0, in_ready=0 while reset is asserted.
  - in_ready rises in the first cycle after reset is released.
  - Reset mid-stream discards the vector and any remaining elements; no out_done is produced.
- Registers:
  - vec_r [ImageSize-1:0][BitSize-1:0].
  - idx_r, width $clog2(ImageSize+Delay+1).
  - state: IDLE / WAIT / SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: vec_r<=in_data, idx_r<=0, next state WAIT if Delay>0, else SEND.
- WAIT:
  - in_ready=0, out_valid=0.
  - idx_r increments each cycle; after exactly Delay cycles in WAIT, next state is SEND with idx_r reset to 0.
  - out_ready is ignored.
- SEND:
  - out_valid=1; out_data = vec_r[ImageSize-1-idx_r], driven combinationally from registers.
  - On out_valid & out_ready: idx_r increments.
  - If idx_r==ImageSize-1 on that beat, out_done=1 that cycle and next state is IDLE.
  - out_ready=0 stalls: out_data and idx_r hold, out_valid stays 1.
- Latency: with Delay=D and out_ready held high, the first element is valid D+1 cycles after the capture edge. Elements then follow on consecutive cycles; out_done coincides with the Nth beat.
- in_ready is 0 outside IDLE, so a vector is never overwritten mid-stream.
  - in_valid asserted during WAIT/SEND is not captured; upstream must hold it.
  - The next vector can be captured the cycle after out_done, giving one bubble per vector.
- ImageSize=1: the single element is both first and last, so out_done asserts on its first accepted beat.
- No arithmetic on data; elements pass bit-exact. The counter never exceeds ImageSize+Delay-1, so no wrap occurs.
- out_done is combinational (out_valid & out_ready & last) and never asserts in IDLE or WAIT.

Test Plan:
1. Delay=0, ImageSize=9, BitSize=2, vector idx[k]=k mod 4, out_ready=1 → capture at edge 0; out_data sequence 0,3,2,1,0,3,2,1,0 (indices 8..0) on cycles 1..9; out_done only on cycle 9; in_ready high again on cycle 10.
2. Delay=3, same vector → out_valid low for cycles 1-3; first element (idx8=0) on cycle 4; out_done on cycle 12.
3. Backpressure: toggle out_ready 1,0,0,1,... during SEND → out_data and index hold on stalled cycles; all 9 elements delivered exactly once, in order; out_done only on the accepted final beat.
4. in_valid held high continuously with two distinct vectors A then B → A fully streamed; in_valid is ignored while streaming; B captured the cycle after A's out_done; B streamed in correct order.
5. Assert res_n for one cycle (asynchronous, mid-clock) after the 4th element of a stream → outputs zero immediately; no out_done; a fresh vector afterwards streams correctly from idx8.
6. Loopback with a flattening PE (Delay=0, in_valid=out_valid&out_ready) → reconstructed vector equals the original vector for 20 random vectors.
